// File: rtl/bit_stuff_codec_pkg.sv
// rtl/bit_stuff_codec_pkg.sv - shared types and constants for the USB bit-stuffing codec
package usb_bs_pkg;

    typedef enum logic {S_DATA, S_STUFF} bs_state_t;

    localparam int BS_MODE_ENCODE   = 0;
    localparam int BS_MODE_DECODE   = 1;
    localparam int BS_RUN_LEN_DEF   = 6;
    localparam int BS_SKIP_LEN_DEF  = 8;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int bs_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_stuff_codec_if.sv
// rtl/bit_stuff_codec_if.sv - upstream/downstream bit-stream handshake bundle
interface bit_stuff_codec_if;

    logic in_valid;
    logic in_bit;
    logic in_last;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_last;
    logic out_ready;

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/bit_stuff_codec_run_counter.sv
// rtl/bit_stuff_codec_run_counter.sv - header index and ones-run counter, flags when a stuff slot is due
module bs_run_counter
    import usb_bs_pkg::*;
#(
    parameter int RUN_LEN  = BS_RUN_LEN_DEF,
    parameter int SKIP_LEN = BS_SKIP_LEN_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic data_hs_i,
    input  logic bit_i,
    input  logic last_i,
    input  logic pkt_end_i,
    input  logic stuff_done_i,
    output logic stuff_due_o
);

    localparam int RUN_W = bs_width(RUN_LEN);
    localparam int IDX_W = bs_width(SKIP_LEN);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             counted;

    assign counted     = (idx_q == IDX_W'(SKIP_LEN));
    assign stuff_due_o = counted && bit_i && !last_i && (run_cnt_q == RUN_W'(RUN_LEN - 1));

    always_comb begin
        run_cnt_d = run_cnt_q;
        idx_d     = idx_q;
        if (pkt_end_i) begin
            run_cnt_d = '0;
            idx_d     = '0;
        end else if (stuff_done_i) begin
            run_cnt_d = '0;
        end else if (data_hs_i) begin
            if (counted) begin
                if (!bit_i) begin
                    run_cnt_d = '0;
                end else if (run_cnt_q != RUN_W'(RUN_LEN)) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end else begin
                // Header bits only advance the index; counted implies saturation.
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: rtl/bit_stuff_codec.sv
// rtl/bit_stuff_codec.sv - NRZ bit stuffer (MODE=0) / destuffer (MODE=1) with pass-through header
module bit_stuff_codec
    import usb_bs_pkg::*;
#(
    parameter int MODE     = BS_MODE_ENCODE,
    parameter int RUN_LEN  = BS_RUN_LEN_DEF,
    parameter int SKIP_LEN = BS_SKIP_LEN_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    bit_stuff_codec_if.slave   bs,
    output logic               stuff_err,
    output logic               busy
);

    bs_state_t state_q, state_d;
    logic      busy_q, busy_d;
    logic      stuff_err_q, stuff_err_d;
    logic      data_hs, in_hs, stuff_done, pkt_end, stuff_due;

    bs_run_counter #(
        .RUN_LEN  (RUN_LEN),
        .SKIP_LEN (SKIP_LEN)
    ) u_run_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .data_hs_i    (data_hs),
        .bit_i        (bs.in_bit),
        .last_i       (bs.in_last),
        .pkt_end_i    (pkt_end),
        .stuff_done_i (stuff_done),
        .stuff_due_o  (stuff_due)
    );

    always_comb begin
        state_d      = state_q;
        bs.out_valid = bs.in_valid;
        bs.out_bit   = bs.in_bit;
        bs.out_last  = bs.in_last;
        bs.in_ready  = bs.out_ready;
        data_hs      = 1'b0;
        in_hs        = 1'b0;
        stuff_done   = 1'b0;
        stuff_err_d  = 1'b0;
        case (state_q)
            S_DATA: begin
                data_hs = bs.in_valid && bs.out_ready;
                in_hs   = data_hs;
                if (data_hs && stuff_due) begin
                    state_d = S_STUFF;
                end
            end
            S_STUFF: begin
                if (MODE == BS_MODE_ENCODE) begin
                    // Emit the inserted zero while holding upstream.
                    bs.out_valid = 1'b1;
                    bs.out_bit   = 1'b0;
                    bs.out_last  = 1'b0;
                    bs.in_ready  = 1'b0;
                    stuff_done   = bs.out_ready;
                end else begin
                    // Swallow the stuff slot; anything but a plain 0 is a violation.
                    bs.out_valid = 1'b0;
                    bs.in_ready  = 1'b1;
                    in_hs        = bs.in_valid;
                    stuff_done   = bs.in_valid;
                    stuff_err_d  = bs.in_valid && (bs.in_bit || bs.in_last);
                end
                if (stuff_done) begin
                    state_d = S_DATA;
                end
            end
        endcase
        pkt_end = in_hs && bs.in_last;
        if (pkt_end) begin
            busy_d = 1'b0;
        end else if (in_hs) begin
            busy_d = 1'b1;
        end else begin
            busy_d = busy_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_DATA;
            busy_q      <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign busy      = busy_q;
    assign stuff_err = stuff_err_q;

endmodule

// File: tb/tb_bit_stuff_codec.sv
// tb/tb_bit_stuff_codec.sv - directed bench for encoder, destuffer and a SKIP_LEN=0 encoder
module tb_bit_stuff_codec;
    import usb_bs_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bit_stuff_codec_if if_e ();
    bit_stuff_codec_if if_d ();
    bit_stuff_codec_if if_z ();

    int   sel;
    logic drv_valid, drv_bit, drv_last, drv_ready;
    logic err_e, err_d, err_z, busy_e, busy_d, busy_z;

    assign if_e.in_valid = (sel == 0) && drv_valid;
    assign if_d.in_valid = (sel == 1) && drv_valid;
    assign if_z.in_valid = (sel == 2) && drv_valid;
    assign if_e.in_bit = drv_bit;  assign if_d.in_bit = drv_bit;  assign if_z.in_bit = drv_bit;
    assign if_e.in_last = drv_last; assign if_d.in_last = drv_last; assign if_z.in_last = drv_last;
    assign if_e.out_ready = drv_ready; assign if_d.out_ready = drv_ready; assign if_z.out_ready = drv_ready;

    bit_stuff_codec #(.MODE(BS_MODE_ENCODE), .RUN_LEN(6), .SKIP_LEN(8)) u_enc (
        .clock(clock), .reset_n(reset_n), .bs(if_e.slave), .stuff_err(err_e), .busy(busy_e));
    bit_stuff_codec #(.MODE(BS_MODE_DECODE), .RUN_LEN(6), .SKIP_LEN(8)) u_dec (
        .clock(clock), .reset_n(reset_n), .bs(if_d.slave), .stuff_err(err_d), .busy(busy_d));
    bit_stuff_codec #(.MODE(BS_MODE_ENCODE), .RUN_LEN(2), .SKIP_LEN(0)) u_zero (
        .clock(clock), .reset_n(reset_n), .bs(if_z.slave), .stuff_err(err_z), .busy(busy_z));

    logic m_in_ready, m_out_valid, m_out_bit, m_out_last, m_err, m_busy;
    always_comb begin
        m_in_ready = if_e.in_ready; m_out_valid = if_e.out_valid; m_out_bit = if_e.out_bit;
        m_out_last = if_e.out_last; m_err = err_e; m_busy = busy_e;
        if (sel == 1) begin
            m_in_ready = if_d.in_ready; m_out_valid = if_d.out_valid; m_out_bit = if_d.out_bit;
            m_out_last = if_d.out_last; m_err = err_d; m_busy = busy_d;
        end else if (sel == 2) begin
            m_in_ready = if_z.in_ready; m_out_valid = if_z.out_valid; m_out_bit = if_z.out_bit;
            m_out_last = if_z.out_last; m_err = err_z; m_busy = busy_z;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] r_ob;
    int r_on, r_lp, r_stalls, r_errs, r_hold, r_busy_last, r_k;

    // Feeds bits[0..n-1] (last on bit n-1), honouring in_ready; out_ready low in [stall_at, stall_at+stall_len).
    task automatic run_pkt(input int s, input logic [63:0] bits, input int n,
                           input int stall_at, input int stall_len);
        int cyc;
        sel = s; r_ob = '0; r_on = 0; r_lp = -1; r_stalls = 0; r_errs = 0;
        r_hold = 0; r_busy_last = 0; r_k = 0; cyc = 0;
        while (r_k < n && cyc < 200) begin
            @(negedge clock);
            drv_valid = 1'b1;
            drv_bit   = bits[r_k];
            drv_last  = (r_k == n - 1);
            drv_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (m_out_valid && drv_ready) begin
                r_ob[r_on] = m_out_bit;
                if (m_out_last) r_lp = r_on;
                r_on++;
            end
            if (!m_in_ready) r_stalls++;
            if (!drv_ready && m_out_valid && !m_out_bit && !m_in_ready) r_hold++;
            if (m_err) r_errs++;
            if (drv_last) r_busy_last = int'(m_busy);
            if (m_in_ready) r_k++;
            cyc++;
        end
        repeat (2) begin
            @(negedge clock);
            drv_valid = 1'b0; drv_last = 1'b0; drv_ready = 1'b1;
            #1;
            if (m_err) r_errs++;
        end
    endtask

    task automatic check_pkt(input string t, input int n, input longint ob, input int on,
                             input int lp, input int stalls, input int errs);
        chk({t, ".done"}, r_k, n);
        chk({t, ".bits"}, r_ob, ob);
        chk({t, ".count"}, r_on, on);
        chk({t, ".last_pos"}, r_lp, lp);
        chk({t, ".in_ready_low"}, r_stalls, stalls);
        chk({t, ".stuff_err"}, r_errs, errs);
        chk({t, ".busy_idle"}, m_busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; sel = 0;
        drv_valid = 1'b0; drv_bit = 1'b0; drv_last = 1'b0; drv_ready = 1'b1;
        repeat (2) @(negedge clock);
        drv_valid = 1'b1; drv_bit = 1'b1; drv_last = 1'b1;
        #1;
        chk("rst.out_valid", if_e.out_valid, 1);
        chk("rst.out_bit", if_e.out_bit, 1);
        chk("rst.out_last", if_e.out_last, 1);
        chk("rst.in_ready", if_e.in_ready, 1);
        chk("rst.busy_e", busy_e, 0);
        chk("rst.busy_d", busy_d, 0);
        chk("rst.err_d", err_d, 0);
        drv_valid = 1'b0; drv_last = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_pkt(0, 64'h3FFF, 15, 1000, 0);
        check_pkt("enc_stuff", 15, 64'h3FFF, 16, 15, 1, 0);
        chk("enc_stuff.busy_mid", r_busy_last, 1);

        run_pkt(0, 64'h3FFF, 14, 1000, 0);
        check_pkt("enc_last6", 14, 64'h3FFF, 14, 13, 0, 0);

        run_pkt(0, 64'h3FFF, 15, 1000, 0);
        check_pkt("enc_after_last6", 15, 64'h3FFF, 16, 15, 1, 0);

        run_pkt(0, 64'h3FFF, 15, 14, 3);
        check_pkt("enc_backpressure", 15, 64'h3FFF, 16, 15, 4, 0);
        chk("enc_backpressure.hold", r_hold, 3);

        run_pkt(1, 64'hBFFF, 16, 1000, 0);
        check_pkt("dec_ok", 16, 64'h7FFF, 15, 14, 0, 0);

        run_pkt(1, 64'h7FFF, 16, 1000, 0);
        check_pkt("dec_violation", 16, 64'h3FFF, 15, 14, 0, 1);

        run_pkt(2, 64'h7, 4, 1000, 0);
        check_pkt("skip0", 4, 64'h0B, 5, 4, 1, 0);

        sel = 0;
        repeat (12) begin
            @(negedge clock);
            drv_valid = 1'b1; drv_bit = 1'b1; drv_last = 1'b0; drv_ready = 1'b1;
        end
        @(negedge clock);
        drv_valid = 1'b0;
        #1;
        chk("rstmid.busy_before", busy_e, 1);
        reset_n = 1'b0;
        #1;
        chk("rstmid.busy_async", busy_e, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_pkt(0, 64'h3FFF, 15, 1000, 0);
        check_pkt("rstmid.next", 15, 64'h3FFF, 16, 15, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_stuff_codec.md
Name: bit_stuff_codec

Overview:
- Parametrised NRZ bit-stuffing engine for the USB serial path.
- MODE selects the direction:
  - encode: inserts a 0 after RUN_LEN consecutive 1s.
  - destuff: removes that inserted 0 and flags a violation.
- Per-packet header bits (PID) are passed through unstuffed and uncounted.
- Sits between the CRC generator and the NRZI encoder on TX; between the NRZI decoder and the packet parser on RX. Both sides use a valid/ready bit stream with a packet-end marker.

Parameters:
- MODE, 0: 0 = encode (stuff), 1 = decode (destuff).
- RUN_LEN, 6: number of consecutive counted 1s that triggers a stuff bit (legal range 2..15).
- SKIP_LEN, 8: number of leading bits of each packet that are neither counted nor stuffed (legal range 0..31).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream bit valid
- in_bit  in  1  upstream data bit
- in_last  in  1  marks the final bit of the packet
- in_ready  out  1  upstream bit accepted when in_valid && in_ready
- out_valid  out  1  downstream bit valid
- out_bit  out  1  downstream data bit
- out_last  out  1  final bit of the packet downstream
- out_ready  in  1  downstream accepts when out_valid && out_ready
- stuff_err  out  1  one-cycle pulse: destuff violation (MODE=1 only; tied 0 in MODE=0)
- busy  out  1  high from the first accepted bit of a packet until the handshake of its last bit

Behaviour:
- Reset (asynchronous):
  - state=S_DATA, run_cnt=0, idx=0, stuff_err=0, busy=0.
  - Combinational outputs then follow S_DATA rules.
  - Reset mid-packet discards the packet; no partial flush.
- Widths:
  - run_cnt is $clog2(RUN_LEN+1) bits and saturates at RUN_LEN.
  - idx is $clog2(SKIP_LEN+1) bits and saturates at SKIP_LEN.
- A bit is "counted" iff idx==SKIP_LEN when it is accepted.
- Handshaking of a counted bit: run_cnt <= in_bit ? run_cnt+1 : 0.
- Handshaking of an uncounted bit: idx <= idx+1; run_cnt unchanged (0).
- in_last handshake: idx<=0, run_cnt<=0, state<=S_DATA, busy<=0; never stuffs or expects a stuff bit after the last bit.
- S_DATA is zero-latency pass-through:
  - out_valid=in_valid, out_bit=in_bit, out_last=in_last, in_ready=out_ready.
- S_DATA -> S_STUFF: on a handshake of a counted 1, not last, with run_cnt==RUN_LEN-1.
- S_STUFF, MODE=0 (encode):
  - out_valid=1, out_bit=0, out_last=0, in_ready=0 (upstream held).
  - On out_ready: run_cnt<=0, return to S_DATA.
- S_STUFF, MODE=1 (destuff):
  - out_valid=0, in_ready=1; the incoming bit is consumed and not forwarded.
  - On in_valid: run_cnt<=0, return to S_DATA.
  - If in_bit==1 or in_last==1: stuff_err=1 on the next cycle for exactly one cycle.
  - If in_last==1: packet-end bookkeeping as above.
- Backpressure:
  - out_ready low holds the current state and counters.
  - A pending stuff bit waits indefinitely.
- busy: set on the handshake of the first bit while idle; cleared on the in_last handshake.
- Back-to-back packets:
  - The first bit of the next packet may handshake on the cycle after in_last.
  - Its idx starts at 0.
- SKIP_LEN=0: every bit is counted.

Decomposition:
- Package usb_bs_pkg:
  - typedef enum logic {S_DATA, S_STUFF} bs_state_t;
  - constants BS_MODE_ENCODE=0, BS_MODE_DECODE=1;
  - default RUN_LEN=6, SKIP_LEN=8.
- One sub-module, bs_run_counter: owns idx/run_cnt and emits a "stuff_due" signal; the FSM and datapath muxes live in bit_stuff_codec.

Test Plan:
- MODE=0, out_ready=1. Packet is 8'hFF PID followed by 1,1,1,1,1,1,0 (last=1 on the final 0) -> output is 8 ones, 6 ones, stuffed 0, 0. in_ready=0 for exactly 1 cycle. out_last only on the final bit.
- MODE=0. 6 ones after the PID, with the 6th carrying in_last -> no stuff bit; out_last on the 6th one; busy falls; the next packet starts with idx=0.
- MODE=0. Stuff pending and out_ready held low for 3 cycles -> out_valid=1, out_bit=0, in_ready=0 throughout; upstream bit released on the cycle after out_ready rises.
- MODE=1. PID, 6 ones, 0, 1(last) -> downstream sees PID, 6 ones, 1(last); the 0 is dropped; stuff_err never asserts.
- MODE=1. PID, 6 ones, 1 (stuff slot), 0(last) -> the bit in the stuff slot is dropped; stuff_err pulses 1 cycle; the following 0 is forwarded with out_last.
- Reset asserted mid-run (run_cnt=4, MODE=0) -> all counters 0 and busy=0 immediately; the next packet needs 6 fresh counted ones before stuffing.
